// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
package multdiv_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned MUL_ITERS = 16;
  localparam int unsigned DIV_ITERS = 32;

  localparam logic [4:0] OP_MUL = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b00111;

  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_e;

endpackage

// File: rtl/multdiv_unit_if.sv
// Operand/strobe/result bundle between execute (master) and the mul/div unit (slave).
interface multdiv_unit_if;

  logic [multdiv_pkg::WIDTH-1:0] data_operandA;
  logic [multdiv_pkg::WIDTH-1:0] data_operandB;
  logic                          ctrl_MULT;
  logic                          ctrl_DIV;
  logic [multdiv_pkg::WIDTH-1:0] data_result;
  logic                          data_exception;
  logic                          data_resultRDY;
  logic                          busy;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
  );

endinterface

// File: rtl/multdiv_unit_booth_recode.sv
// Radix-4 modified Booth recoder: 3-bit multiplier window -> {0,+-1,+-2} x multiplicand.
module booth_recode
  import multdiv_pkg::*;
(
  input  logic [2:0]       win_i,
  input  logic [WIDTH-1:0] mcand_i,
  output logic [WIDTH+1:0] pp_c_o
);

  logic [WIDTH+1:0] m1;
  logic [WIDTH+1:0] m2;

  always_comb begin
    m1 = {{2{mcand_i[WIDTH-1]}}, mcand_i};
    m2 = {mcand_i[WIDTH-1], mcand_i, 1'b0};
    case (win_i)
      3'b001, 3'b010: pp_c_o = m1;
      3'b011:         pp_c_o = m2;
      3'b100:         pp_c_o = -m2;
      3'b101, 3'b110: pp_c_o = -m1;
      default:        pp_c_o = '0;
    endcase
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (radix-4 Booth, 18 edges) / divide (non-restoring, 34 edges).
// MULTDIV_EARLY_DIV0_EN: divide-by-zero skips straight to FIX, completing at E2.
module multdiv_unit
  import multdiv_pkg::*;
(
  input logic           clock,
  input logic           reset,
  multdiv_unit_if.slave bus
);

  localparam int unsigned PW = 2*WIDTH + 2;
  localparam int unsigned CW = 5;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             is_mul_q, is_mul_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;
  logic             flag_q, flag_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;

  logic [WIDTH+1:0] pp;
  logic [WIDTH+1:0] bsum;
  logic [WIDTH+1:0] dshift;
  logic [WIDTH+1:0] dsum;
  logic [WIDTH-1:0] mag_a, mag_b, quo;
  logic [WIDTH:0]   hi_bits;

  booth_recode u_booth (
    .win_i   (prod_q[2:0]),
    .mcand_i (opnd_q),
    .pp_c_o  (pp)
  );

  // prod_q = {acc/remainder[32:0], multiplier/quotient[31:0], booth guard bit}
  assign bsum    = {prod_q[PW-1], prod_q[PW-1:WIDTH+1]} + pp;
  assign dshift  = {prod_q[PW-1:WIDTH+1], prod_q[WIDTH]};
  assign dsum    = prod_q[PW-1] ? dshift + {2'b00, opnd_q} : dshift - {2'b00, opnd_q};
  assign quo     = prod_q[WIDTH:1];
  assign hi_bits = prod_q[2*WIDTH:WIDTH];
  assign mag_a   = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign mag_b   = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      is_mul_q <= 1'b0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      flag_q   <= 1'b0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      is_mul_q <= is_mul_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      flag_q   <= flag_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  // A start strobe in any state (re)launches an operation; MULT has priority over DIV.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    is_mul_d = is_mul_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    flag_d   = flag_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    busy_d   = busy_q;

    if (bus.ctrl_MULT) begin
      state_d  = MUL;
      cnt_d    = '0;
      busy_d   = 1'b1;
      is_mul_d = 1'b1;
      opnd_d   = bus.data_operandA;
      prod_d   = {{(WIDTH+1){1'b0}}, bus.data_operandB, 1'b0};
    end else if (bus.ctrl_DIV) begin
      state_d  = DIV;
      cnt_d    = '0;
      busy_d   = 1'b1;
      is_mul_d = 1'b0;
      opnd_d   = mag_b;
      prod_d   = {{(WIDTH+1){1'b0}}, mag_a, 1'b0};
      neg_d    = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      zero_d   = (bus.data_operandB == '0);
      flag_d   = (bus.data_operandB == '0) ||
                 ((bus.data_operandA == INT_MIN) && (bus.data_operandB == '1));
`ifdef MULTDIV_EARLY_DIV0_EN
      if (bus.data_operandB == '0) state_d = FIX;
`else
      state_d  = DIV;
`endif
    end else begin
      case (state_q)
        MUL: begin
          prod_d = {bsum[WIDTH+1], bsum, prod_q[WIDTH:2]};
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(MUL_ITERS-1)) state_d = FIX;
        end
        DIV: begin
          prod_d = {dsum[WIDTH:0], quo[WIDTH-2:0], ~dsum[WIDTH+1], 1'b0};
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(DIV_ITERS-1)) state_d = FIX;
        end
        FIX: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          rdy_d   = 1'b1;
          if (is_mul_q) begin
            result_d = quo;
            exc_d    = !((&hi_bits) || !(|hi_bits));
          end else begin
            result_d = zero_q ? '0 : (neg_q ? -quo : quo);
            exc_d    = flag_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;

endmodule
